traffic_light_monitor: RTL and testbench
========================================

TRAFFIC_LIGHT_MONITOR -- requirements
Module: traffic_light_monitor

Interface
REQ-001 SHALL have parameter DARK_MAX, default 3: max consecutive all-dark samples tolerated while locked.
REQ-002 SHALL have parameter MIN_DWELL, default 1: min samples per phase (used only under REQ-030).
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports red, yellow, green  input  1 each  lamp drives from the light controller.
REQ-006 SHALL have port clr_err  input  1  clears sticky error flags.
REQ-007 SHALL have port phase  output  2  decoded phase: 00 none, 01 red, 10 yellow, 11 green.
REQ-008 SHALL have port locked  output  1  monitor is tracking a legal sequence.
REQ-009 SHALL have ports err_multi, err_seq, err_dark, err_dwell  output  1 each  sticky error flags.
REQ-010 SHALL have port cycle_count  output  8  completed green-yellow-red cycles.

Function
REQ-011 SHALL sample red/yellow/green every rising edge; all outputs registered, reflecting a sample one cycle after it is presented.
REQ-012 SHALL classify each sample: single (exactly one lamp), dark (none), multi (two or more).
REQ-013 SHALL implement FSM states SYNC, GREEN, YELLOW, RED; state drives phase (SYNC -> 00).
REQ-014 SHALL, in SYNC, move to the phase of the first single sample, with locked=0 in SYNC and 1 otherwise.
REQ-015 SHALL treat GREEN->YELLOW, YELLOW->RED, RED->GREEN, and same-phase repeats as legal.
REQ-016 SHALL, on a single sample of any other phase while locked, set err_seq and move to that sample's phase.
REQ-017 SHALL, on a multi sample, set err_multi and hold state and all counters.
REQ-018 SHALL count consecutive dark samples while locked and hold state; a non-dark sample resets the count to 0.
REQ-019 SHALL, when the dark count reaches DARK_MAX+1, set err_dark, return to SYNC, and clear the count.
REQ-020 SHALL ignore dark samples in SYNC: no error, no count.
REQ-021 SHALL increment cycle_count on each legal RED->GREEN transition, wrapping 255->0.
REQ-022 SHALL leave cycle_count unchanged on illegal transitions and on the SYNC->GREEN entry.
REQ-023 SHALL clear all four error flags the cycle after clr_err=1.
REQ-024 SHALL give priority to setting when an error event and clr_err occur in the same cycle.

Reset
REQ-025 SHALL, on rst=1 at a rising edge: state SYNC, phase=00, locked=0, all error flags 0, cycle_count=0, dark and dwell counters 0.
REQ-026 SHALL let rst take priority over every other input, including mid-phase and during a dark run.
REQ-027 SHALL begin sampling on the first edge after rst deasserts.

Configuration
REQ-028 SHALL use macro TLM_DWELL_CHECK_EN.
REQ-029 SHALL, when the macro is defined, count samples in the current locked phase (saturating at 255, reset on phase change).
REQ-030 SHALL, when the macro is defined, set err_dwell when a phase change leaves a phase after fewer than MIN_DWELL samples; SYNC entry is exempt.
REQ-031 SHALL, when the macro is undefined, tie err_dwell to 0, omit the dwell counter, and keep ports unchanged.

Verification
REQ-032 SHALL cover: rst, then samples dark,G,Y,R,G -> phase 00,11,10,01,11; locked=1 from the G sample; cycle_count=1; no errors.
REQ-033 SHALL cover: locked in GREEN, then sample R -> err_seq=1, phase=01, cycle_count unchanged.
REQ-034 SHALL cover: locked in YELLOW, then sample R+G -> err_multi=1, phase stays 10; the next sample R is legal.
REQ-035 SHALL cover, with DARK_MAX=3 and locked in RED: 3 dark samples give no error; a 4th gives err_dark=1, phase=00, locked=0.
REQ-036 SHALL cover: 256 legal cycles -> cycle_count wraps to 0; clr_err concurrent with err_seq event -> err_seq stays 1.
REQ-037 SHALL cover, with TLM_DWELL_CHECK_EN and MIN_DWELL=2: G,G,Y -> no err_dwell; then Y followed by R (one sample) -> err_dwell=1; without the macro, the same stimulus gives err_dwell=0.

Source files
------------

// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor: watches the lamp drives of a traffic light controller.
// It decodes the current phase, tracks the legal G->Y->R->G sequence and raises
// sticky error flags for multi-lamp, out-of-sequence and over-long dark samples.
// It also counts completed cycles.
// Optional feature: define TLM_DWELL_CHECK_EN to enable the minimum-dwell check.
// That check drives err_dwell and uses MIN_DWELL. With the macro undefined,
// err_dwell is tied to 0.
module traffic_light_monitor #(
  parameter int DARK_MAX  = 3,
  parameter int MIN_DWELL = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       red,
  input  logic       yellow,
  input  logic       green,
  input  logic       clr_err,
  output logic [1:0] phase,
  output logic       locked,
  output logic       err_multi,
  output logic       err_seq,
  output logic       err_dark,
  output logic       err_dwell,
  output logic [7:0] cycle_count
);

  // State codes equal the phase output encoding, so phase is the state register.
  localparam logic [1:0] ST_SYNC   = 2'b00;
  localparam logic [1:0] ST_RED    = 2'b01;
  localparam logic [1:0] ST_YELLOW = 2'b10;
  localparam logic [1:0] ST_GREEN  = 2'b11;

  // Dark counter must hold DARK_MAX+1 without overflow.
  localparam int DCW = $clog2(DARK_MAX + 2);

  logic [1:0]     r_state;
  logic           r_locked;
  logic           r_err_multi;
  logic           r_err_seq;
  logic           r_err_dark;
  logic [7:0]     r_cycle_cnt;
  logic [DCW-1:0] r_dark_cnt;

  logic [1:0]     w_lamp_cnt;
  logic           w_single;
  logic           w_dark;
  logic           w_multi;
  logic [1:0]     w_sample_ph;
  logic           w_legal;
  logic [1:0]     w_state_nxt;
  logic [DCW-1:0] w_dark_nxt;
  logic [7:0]     w_cycle_nxt;
  logic           w_set_multi;
  logic           w_set_seq;
  logic           w_set_dark;

  assign w_lamp_cnt = {1'b0, red} + {1'b0, yellow} + {1'b0, green};
  assign w_single   = (w_lamp_cnt == 2'd1);
  assign w_dark     = (w_lamp_cnt == 2'd0);
  assign w_multi    = ~w_single & ~w_dark;

  // Decode the sampled lamps into a phase code and check sequence legality.
  always_comb begin
    w_sample_ph = ST_SYNC;
    w_legal     = 1'b0;
    case ({red, yellow, green})
      3'b100:  w_sample_ph = ST_RED;
      3'b010:  w_sample_ph = ST_YELLOW;
      3'b001:  w_sample_ph = ST_GREEN;
      default: w_sample_ph = ST_SYNC;
    endcase
    case (r_state)
      ST_GREEN:  w_legal = (w_sample_ph == ST_YELLOW);
      ST_YELLOW: w_legal = (w_sample_ph == ST_RED);
      ST_RED:    w_legal = (w_sample_ph == ST_GREEN);
      default:   w_legal = 1'b0;
    endcase
  end

  // Next-state, dark-run and cycle-count logic for one sample.
  always_comb begin
    w_state_nxt = r_state;
    w_dark_nxt  = r_dark_cnt;
    w_cycle_nxt = r_cycle_cnt;
    w_set_multi = 1'b0;
    w_set_seq   = 1'b0;
    w_set_dark  = 1'b0;
    if (w_multi) begin
      // Ambiguous sample: flag it and freeze everything.
      w_set_multi = 1'b1;
    end else if (w_dark) begin
      if (r_state == ST_SYNC) begin
        w_dark_nxt = r_dark_cnt;
      end else if (r_dark_cnt == DCW'(DARK_MAX)) begin
        w_set_dark  = 1'b1;
        w_state_nxt = ST_SYNC;
        w_dark_nxt  = '0;
      end else begin
        w_dark_nxt = r_dark_cnt + DCW'(1);
      end
    end else begin
      w_dark_nxt = '0;
      if (r_state == ST_SYNC) begin
        // Acquire lock on the first clean sample; never counted as a cycle.
        w_state_nxt = w_sample_ph;
      end else if (w_sample_ph == r_state) begin
        w_state_nxt = r_state;
      end else begin
        w_state_nxt = w_sample_ph;
        if (!w_legal) begin
          w_set_seq = 1'b1;
        end else if (r_state == ST_RED) begin
          w_cycle_nxt = r_cycle_cnt + 8'd1;
        end else begin
          w_cycle_nxt = r_cycle_cnt;
        end
      end
    end
  end

  // Main state and sticky-flag registers; a set event beats clr_err.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_SYNC;
      r_locked    <= 1'b0;
      r_err_multi <= 1'b0;
      r_err_seq   <= 1'b0;
      r_err_dark  <= 1'b0;
      r_cycle_cnt <= 8'd0;
      r_dark_cnt  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_locked    <= (w_state_nxt != ST_SYNC);
      r_err_multi <= w_set_multi | (r_err_multi & ~clr_err);
      r_err_seq   <= w_set_seq   | (r_err_seq   & ~clr_err);
      r_err_dark  <= w_set_dark  | (r_err_dark  & ~clr_err);
      r_cycle_cnt <= w_cycle_nxt;
      r_dark_cnt  <= w_dark_nxt;
    end
  end

`ifdef TLM_DWELL_CHECK_EN
  localparam logic [8:0] MIN_DWELL_W = 9'(MIN_DWELL);

  logic [7:0] r_dwell_cnt;
  logic [7:0] w_dwell_nxt;
  logic       w_phase_change;
  logic       w_set_dwell;
  logic       r_err_dwell;

  assign w_phase_change = w_single & (r_state != ST_SYNC) & (w_sample_ph != r_state);

  // Count samples spent in the current locked phase and flag short phases.
  always_comb begin
    w_dwell_nxt = r_dwell_cnt;
    w_set_dwell = 1'b0;
    if (w_multi) begin
      w_dwell_nxt = r_dwell_cnt;
    end else if (w_dark) begin
      if (w_set_dark) begin
        w_dwell_nxt = 8'd0;
      end else begin
        w_dwell_nxt = r_dwell_cnt;
      end
    end else if (r_state == ST_SYNC) begin
      // Entering from SYNC is exempt; the entry sample is the first one counted.
      w_dwell_nxt = 8'd1;
    end else if (w_phase_change) begin
      w_dwell_nxt = 8'd1;
      w_set_dwell = ({1'b0, r_dwell_cnt} < MIN_DWELL_W);
    end else if (r_dwell_cnt != 8'd255) begin
      w_dwell_nxt = r_dwell_cnt + 8'd1;
    end else begin
      w_dwell_nxt = r_dwell_cnt;
    end
  end

  // Dwell counter and its sticky error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dwell_cnt <= 8'd0;
      r_err_dwell <= 1'b0;
    end else begin
      r_dwell_cnt <= w_dwell_nxt;
      r_err_dwell <= w_set_dwell | (r_err_dwell & ~clr_err);
    end
  end

  assign err_dwell = r_err_dwell;
`else
  assign err_dwell = 1'b0;
`endif

  assign phase       = r_state;
  assign locked      = r_locked;
  assign err_multi   = r_err_multi;
  assign err_seq     = r_err_seq;
  assign err_dark    = r_err_dark;
  assign cycle_count = r_cycle_cnt;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Scoreboard bench for traffic_light_monitor: a driver applies samples on the
// falling edge, a spec-level model predicts the registered outputs and queues
// them, and a monitor compares them just after the next rising edge.
module tb_traffic_light_monitor;

  localparam int DARK_MAX  = 3;
  localparam int MIN_DWELL = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       red = 1'b0, yellow = 1'b0, green = 1'b0, clr_err = 1'b0;
  logic [1:0] phase;
  logic       locked, err_multi, err_seq, err_dark, err_dwell;
  logic [7:0] cycle_count;

  traffic_light_monitor #(.DARK_MAX(DARK_MAX), .MIN_DWELL(MIN_DWELL)) dut (
    .clk(clk), .rst(rst), .red(red), .yellow(yellow), .green(green),
    .clr_err(clr_err), .phase(phase), .locked(locked),
    .err_multi(err_multi), .err_seq(err_seq), .err_dark(err_dark),
    .err_dwell(err_dwell), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] ph;
    logic       lk, em, es, ed, ew;
    logic [7:0] cc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: phase 0 none, 1 red, 2 yellow, 3 green.
  int m_phase = 0, m_dark = 0, m_cycles = 0, m_dwell = 0;
  bit m_em = 0, m_es = 0, m_ed = 0, m_ew = 0;

  // Legal successor in the green -> yellow -> red -> green ring.
  function automatic int succ(input int p);
    return (p == 1) ? 3 : p - 1;
  endfunction

  task automatic model_step(input bit rs, input bit r, input bit y, input bit g, input bit clr);
    int n, sp;
    bit sm, ss, sd, sw;
    if (rs) begin
      m_phase = 0; m_dark = 0; m_cycles = 0; m_dwell = 0;
      m_em = 0; m_es = 0; m_ed = 0; m_ew = 0;
      return;
    end
    n  = int'(r) + int'(y) + int'(g);
    sp = r ? 1 : (y ? 2 : (g ? 3 : 0));
    sm = 0; ss = 0; sd = 0; sw = 0;
    if (n > 1) begin
      sm = 1;
    end else if (n == 0) begin
      if (m_phase != 0) begin
        m_dark++;
        if (m_dark > DARK_MAX) begin
          sd = 1; m_phase = 0; m_dark = 0; m_dwell = 0;
        end
      end
    end else begin
      m_dark = 0;
      if (m_phase == 0) begin
        m_phase = sp; m_dwell = 1;
      end else if (sp == m_phase) begin
        if (m_dwell < 255) m_dwell++;
      end else begin
        if (m_dwell < MIN_DWELL) sw = 1;
        if (sp == succ(m_phase)) begin
          if (m_phase == 1) m_cycles = (m_cycles + 1) % 256;
        end else begin
          ss = 1;
        end
        m_phase = sp; m_dwell = 1;
      end
    end
    m_em = sm | (m_em & !clr);
    m_es = ss | (m_es & !clr);
    m_ed = sd | (m_ed & !clr);
`ifdef TLM_DWELL_CHECK_EN
    m_ew = sw | (m_ew & !clr);
`else
    m_ew = 0;
`endif
  endtask

  // Apply one sample and queue the outputs it must produce.
  task automatic drive(input bit rs, input bit r, input bit y, input bit g, input bit clr);
    exp_t e;
    @(negedge clk);
    rst = rs; red = r; yellow = y; green = g; clr_err = clr;
    model_step(rs, r, y, g, clr);
    e.ph = 2'(m_phase);
    e.lk = (m_phase != 0);
    e.em = m_em; e.es = m_es; e.ed = m_ed; e.ew = m_ew;
    e.cc = 8'(m_cycles);
    exp_q.push_back(e);
  endtask

  // Drive a phase code (0 = dark) as a single-lamp sample.
  task automatic drive_ph(input int p, input bit clr);
    drive(1'b0, p == 1, p == 2, p == 3, clr);
  endtask

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  // Monitor: outputs are valid every cycle; compare against queued expectations.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("phase",       8'(phase),     8'(e.ph));
      chk("locked",      8'(locked),    8'(e.lk));
      chk("err_multi",   8'(err_multi), 8'(e.em));
      chk("err_seq",     8'(err_seq),   8'(e.es));
      chk("err_dark",    8'(err_dark),  8'(e.ed));
      chk("err_dwell",   8'(err_dwell), 8'(e.ew));
      chk("cycle_count", cycle_count,   e.cc);
    end
  end

  initial begin
    int k;
    // Reset state.
    drive(1'b1, 0, 0, 0, 0);
    drive(1'b1, 0, 0, 0, 0);
    // Lock-up sequence: dark, G, Y, R, G.
    drive_ph(0, 0); drive_ph(3, 0); drive_ph(2, 0); drive_ph(1, 0); drive_ph(3, 0);
    // Out-of-sequence G -> R, then clear while doing a legal R -> G.
    drive_ph(1, 0); drive_ph(3, 1); drive_ph(3, 0);
    // Multi-lamp sample in YELLOW, then a legal R.
    drive_ph(2, 0); drive(1'b0, 1, 0, 1, 0); drive_ph(1, 0);
    // Dark run in RED: three tolerated, fourth drops lock.
    drive_ph(1, 0); drive_ph(0, 0); drive_ph(0, 0); drive_ph(0, 0); drive_ph(0, 0);
    drive_ph(0, 0); drive_ph(0, 1); drive_ph(0, 0);
    // Reset in the middle of a dark run, then a fresh dark run.
    drive_ph(3, 0); drive_ph(0, 0); drive_ph(0, 0);
    drive(1'b1, 0, 0, 0, 0);
    drive_ph(3, 0); drive_ph(0, 0); drive_ph(0, 0); drive_ph(0, 0); drive_ph(3, 0);
    // 256 full cycles from a clean reset wrap cycle_count to 0.
    drive(1'b1, 0, 0, 0, 0);
    drive_ph(3, 0);
    for (int i = 0; i < 256; i++) begin
      drive_ph(2, 0); drive_ph(1, 0); drive_ph(3, 0);
    end
    // clr_err together with an err_seq event: set wins.
    drive_ph(1, 1); drive_ph(1, 0); drive_ph(3, 1); drive_ph(3, 0);
    // Dwell scenario: G, G, Y, then R after a single Y sample.
    drive(1'b1, 0, 0, 0, 0);
    drive_ph(3, 0); drive_ph(3, 0); drive_ph(2, 0); drive_ph(1, 0); drive_ph(1, 0);
    drive_ph(1, 1); drive_ph(1, 0);
    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      k = int'($urandom_range(0, 99));
      if ($urandom_range(0, 149) == 0) begin
        drive(1'b1, 0, 0, 0, 0);
      end else if (k < 45) begin
        drive_ph((m_phase == 0) ? 3 : succ(m_phase), $urandom_range(0, 19) == 0);
      end else if (k < 65) begin
        drive_ph(m_phase, $urandom_range(0, 19) == 0);
      end else if (k < 80) begin
        drive_ph(0, $urandom_range(0, 19) == 0);
      end else if (k < 92) begin
        drive_ph(int'($urandom_range(1, 3)), $urandom_range(0, 19) == 0);
      end else begin
        k = int'($urandom_range(3, 7));
        drive(1'b0, k[2], k[1], k[0] | (k == 4), $urandom_range(0, 19) == 0);
      end
    end
    repeat (2) @(posedge clk);
    #2;
    chk("scoreboard_drained", 8'(exp_q.size()), 8'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
